// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the two-port SDRAM controller arbiter.
package sdram_arb_pkg;

  localparam int unsigned ADDR_W_DEF  = 26;
  localparam int unsigned TIMEOUT_DEF = 1024;
  localparam int unsigned TO_W_DEF    = 10;
  localparam int unsigned DATA_W      = 8;

  localparam logic [DATA_W-1:0] ERR_RDATA = 8'hFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the port that did not win last time is chosen.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       valid
);

  always_comb begin
    valid = |req;
    gnt   = (&req) ? ~last : req[1];
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one byte-wide SDRAM controller between a CPU port (0) and a DMA port (1),
// issuing one strobe per command and returning data with a one-cycle ack.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned TO_W    = TO_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_ack,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_stb,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              grant
);

  state_t            state, state_d;
  logic              last, last_d;
  logic [TO_W-1:0]   cnt, cnt_d, cnt_inc;
  logic [ADDR_W-1:0] addr_d;
  logic              we_d, stb_d, busy_d, grant_d;
  logic [DATA_W-1:0] wdata_d, rdata0_d, rdata1_d, fin_data;
  logic              ack0_d, ack1_d, err0_d, err1_d;
  logic              pick, pick_valid, finish, fin_err;

  rr_arb2 u_arb (
    .req   ({p1_req, p0_req}),
    .last  (last),
    .gnt   (pick),
    .valid (pick_valid)
  );

  assign cnt_inc = cnt + TO_W'(1);

  // Next-state and next-output logic; every register is computed here.
  always_comb begin
    state_d  = state;
    last_d   = last;
    cnt_d    = cnt;
    addr_d   = mem_address;
    we_d     = mem_we;
    wdata_d  = mem_wdata;
    stb_d    = 1'b0;
    grant_d  = grant;
    rdata0_d = p0_rdata;
    rdata1_d = p1_rdata;
    err0_d   = p0_err;
    err1_d   = p1_err;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    finish   = 1'b0;
    fin_err  = 1'b0;
    fin_data = '0;

    case (state)
      IDLE: begin
        // Waiting for ready also lets an operation orphaned by reset drain.
        if (mem_ready && pick_valid) begin
          state_d = ISSUE;
          grant_d = pick;
          last_d  = pick;
          addr_d  = pick ? p1_addr  : p0_addr;
          we_d    = pick ? p1_we    : p0_we;
          wdata_d = pick ? p1_wdata : p0_wdata;
          stb_d   = 1'b1;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_LO;
      end
      WAIT_LO, WAIT_HI: begin
        cnt_d = cnt_inc;
        if (cnt_inc == TO_W'(TIMEOUT - 1)) begin
          finish   = 1'b1;
          fin_err  = 1'b1;
          fin_data = ERR_RDATA;
        end else if (state == WAIT_LO) begin
          if (!mem_ready) state_d = WAIT_HI;
        end else if (mem_ready) begin
          finish   = 1'b1;
          fin_data = mem_rdata;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d = DONE;
      if (grant) begin
        ack1_d   = 1'b1;
        err1_d   = fin_err;
        rdata1_d = fin_data;
      end else begin
        ack0_d   = 1'b1;
        err0_d   = fin_err;
        rdata0_d = fin_data;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      last        <= 1'b1;
      cnt         <= '0;
      mem_address <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      mem_stb     <= 1'b0;
      grant       <= 1'b0;
      busy        <= 1'b0;
      p0_rdata    <= '0;
      p0_ack      <= 1'b0;
      p0_err      <= 1'b0;
      p1_rdata    <= '0;
      p1_ack      <= 1'b0;
      p1_err      <= 1'b0;
    end else begin
      state       <= state_d;
      last        <= last_d;
      cnt         <= cnt_d;
      mem_address <= addr_d;
      mem_we      <= we_d;
      mem_wdata   <= wdata_d;
      mem_stb     <= stb_d;
      grant       <= grant_d;
      busy        <= busy_d;
      p0_rdata    <= rdata0_d;
      p0_ack      <= ack0_d;
      p0_err      <= err0_d;
      p1_rdata    <= rdata1_d;
      p1_ack      <= ack1_d;
      p1_err      <= err1_d;
    end
  end

endmodule
